// File: rtl/frame_update_arbiter_pkg.sv
// Shared types and helpers for the frame update arbiter: FSM state encoding,
// budget counter width and the vblank edge detector.
package frame_update_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARB   = 3'd1,
    WRITE = 3'd2,
    HOLD  = 3'd3,
    CLOSE = 3'd4
  } arb_state_t;

  localparam int BUDGET_W = 8;

  // Rising edge of a level, given its value registered one cycle earlier.
  function automatic logic vblank_edge(input logic cur, input logic prev);
    return cur & ~prev;
  endfunction

endpackage

// File: rtl/frame_update_arbiter_rr_pick.sv
// Combinational round-robin selector: the first requester at or after ptr+1
// (mod N) wins; returns it one-hot, as an index, and whether anyone requested.
module rr_pick #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     onehot,
  output logic [PTR_W-1:0] idx,
  output logic             any
);

  int cand_s;

  // Scan requesters in rotated order, keeping only the first hit.
  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    cand_s = 0;
    for (int k = 1; k <= N; k++) begin
      cand_s = (int'(ptr) + k) % N;
      if (!any && req[cand_s]) begin
        onehot[cand_s] = 1'b1;
        idx            = cand_s[PTR_W-1:0];
        any            = 1'b1;
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/frame_update_arbiter.sv
// Grants game-logic register-file writes only inside vertical blanking, round-robin
// with a per-window budget. Define FRAME_ARB_STATS_EN to add wr_count/starve_frames.
module frame_update_arbiter
  import frame_update_arbiter_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 6,
  parameter int DATA_W = 16,
  parameter int MAX_WR = 32
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    vblank,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        gnt,
  output logic                    reg_we,
  output logic [ADDR_W-1:0]       reg_addr,
  output logic [DATA_W-1:0]       reg_wdata,
  output logic                    win_open,
  output logic                    frame_done,
  output logic                    starved
`ifdef FRAME_ARB_STATS_EN
  ,
  output logic [7:0]              wr_count,
  output logic [15:0]             starve_frames
`endif
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_t          state_r, state_s;
  logic                vblank_r;
  logic                vblank_rise_s;
  logic [BUDGET_W-1:0] budget_r, budget_s;
  logic [PTR_W-1:0]    ptr_r, ptr_s;

  logic [N_REQ-1:0]    gnt_s;
  logic                reg_we_s;
  logic [ADDR_W-1:0]   reg_addr_s;
  logic [DATA_W-1:0]   reg_wdata_s;
  logic                win_open_s;
  logic                frame_done_s;
  logic                starved_s;

  logic [N_REQ-1:0]    pick_onehot_s;
  logic [PTR_W-1:0]    pick_idx_s;
  logic                pick_any_s;

  assign vblank_rise_s = vblank_edge(vblank, vblank_r);

  rr_pick #(
    .N     (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .req    (req),
    .ptr    (ptr_r),
    .onehot (pick_onehot_s),
    .idx    (pick_idx_s),
    .any    (pick_any_s)
  );

  // State, arbitration bookkeeping and all outputs are registered here.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= IDLE;
      vblank_r   <= 1'b0;
      budget_r   <= '0;
      ptr_r      <= PTR_W'(N_REQ - 1);
      gnt        <= '0;
      reg_we     <= 1'b0;
      reg_addr   <= '0;
      reg_wdata  <= '0;
      win_open   <= 1'b0;
      frame_done <= 1'b0;
      starved    <= 1'b0;
    end else begin
      state_r    <= state_s;
      vblank_r   <= vblank;
      budget_r   <= budget_s;
      ptr_r      <= ptr_s;
      gnt        <= gnt_s;
      reg_we     <= reg_we_s;
      reg_addr   <= reg_addr_s;
      reg_wdata  <= reg_wdata_s;
      win_open   <= win_open_s;
      frame_done <= frame_done_s;
      starved    <= starved_s;
    end
  end

  // Next state and next output values; WRITE gives every grant a dead cycle so a
  // requester is never sampled twice before it can drop req.
  always_comb begin
    state_s      = state_r;
    budget_s     = budget_r;
    ptr_s        = ptr_r;
    gnt_s        = '0;
    reg_we_s     = 1'b0;
    reg_addr_s   = reg_addr;
    reg_wdata_s  = reg_wdata;
    win_open_s   = win_open;
    frame_done_s = 1'b0;
    starved_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (vblank_rise_s) begin
          budget_s   = BUDGET_W'(MAX_WR);
          win_open_s = 1'b1;
          state_s    = ARB;
        end else begin
          state_s = IDLE;
        end
      end
      ARB: begin
        if (!vblank) begin
          win_open_s   = 1'b0;
          frame_done_s = 1'b1;
          starved_s    = |req;
          state_s      = CLOSE;
        end else if (budget_r == '0) begin
          win_open_s = 1'b0;
          state_s    = HOLD;
        end else if (pick_any_s) begin
          gnt_s       = pick_onehot_s;
          reg_we_s    = 1'b1;
          reg_addr_s  = req_addr[int'(pick_idx_s)*ADDR_W +: ADDR_W];
          reg_wdata_s = req_data[int'(pick_idx_s)*DATA_W +: DATA_W];
          ptr_s       = pick_idx_s;
          budget_s    = budget_r - BUDGET_W'(1);
          state_s     = WRITE;
        end else begin
          state_s = ARB;
        end
      end
      WRITE: begin
        state_s = ARB;
      end
      HOLD: begin
        if (!vblank) begin
          frame_done_s = 1'b1;
          starved_s    = |req;
          state_s      = CLOSE;
        end else begin
          state_s = HOLD;
        end
      end
      CLOSE: begin
        win_open_s = 1'b0;
        state_s    = IDLE;
      end
      default: begin
        win_open_s = 1'b0;
        state_s    = IDLE;
      end
    endcase
  end

`ifdef FRAME_ARB_STATS_EN
  logic [7:0] wr_cnt_r;

  // Per-window write count, latched at close; saturating count of starved frames.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_cnt_r      <= 8'd0;
      wr_count      <= 8'd0;
      starve_frames <= 16'd0;
    end else begin
      if (state_r == IDLE && state_s == ARB) begin
        wr_cnt_r <= 8'd0;
      end else if (reg_we_s) begin
        wr_cnt_r <= wr_cnt_r + 8'd1;
      end else begin
        wr_cnt_r <= wr_cnt_r;
      end
      if (frame_done_s) begin
        wr_count <= wr_cnt_r;
      end else begin
        wr_count <= wr_count;
      end
      if (frame_done_s && starved_s && (starve_frames != 16'hFFFF)) begin
        starve_frames <= starve_frames + 16'd1;
      end else begin
        starve_frames <= starve_frames;
      end
    end
  end
`endif

endmodule
